// File: rtl/img_mem_pkg.sv
// Shared types and default sizing for the image memory responder.
package img_mem_pkg;

  localparam int DATA_SIZE_DEF = 16;
  localparam int N_DEF         = 32;
  localparam int ADDR_W_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_LAST,
    SAVE,
    DONE
  } state_t;

  // A full n*n word count needs one bit more than the flat index range.
  function automatic int cntWidth(input int n);
    return 2 * $clog2(n) + 1;
  endfunction

  function automatic int idxWidth(input int n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/mem_seq_counter.sv
// Walks word index k and RAM address base+k across one image transfer.
module mem_seq_counter #(
  parameter int ADDR_W = 16,
  parameter int CW     = 11,
  parameter int IW     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] addr,
  output logic [IW-1:0]     idx,
  output logic              last
);

  logic [CW-1:0] countReg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      idx      <= '0;
      countReg <= '0;
    end else if (start) begin
      addr     <= base;
      idx      <= '0;
      countReg <= count;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      idx  <= idx + IW'(1);
    end
  end

  assign last = (CW'(idx) == countReg - CW'(1));

endmodule

// File: rtl/img_mem_responder.sv
// Serves image load/save requests from the layer controllers against a
// synchronous single-port feature-map RAM with one-cycle read latency.
module img_mem_responder
  import img_mem_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int N         = N_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic                 save_en,
  input  logic [ADDR_W-1:0]    save_addr,
  input  logic [DATA_SIZE-1:0] img_size,
  input  logic [DATA_SIZE-1:0] save_img [N*N],
  output logic [DATA_SIZE-1:0] image_out [N*N],
  output logic                 op_done,
  output logic                 busy,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  localparam int CW = cntWidth(N);
  localparam int IW = idxWidth(N);
  localparam int SW = $clog2(N) + 1;

  state_t            state;
  logic [SW-1:0]     side;
  logic [CW-1:0]     reqCount;
  logic [ADDR_W-1:0] reqBase;
  logic              accept;
  logic              step;
  logic              last;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     nextIdx;
  logic [IW-1:0]     capIdx;
  logic              capValid;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    side = img_size[SW-1:0];
    if (img_size > DATA_SIZE'(N)) side = SW'(N);
    reqCount = CW'(side) * CW'(side);
  end

  assign accept  = (state == IDLE) && (load_en || save_en);
  assign reqBase = load_en ? load_addr : save_addr;
  assign step    = ((state == LOAD) || (state == SAVE)) && !last;
  assign nextIdx = idx + IW'(1);

  mem_seq_counter #(
    .ADDR_W (ADDR_W),
    .CW     (CW),
    .IW     (IW)
  ) u_seq (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .step  (step),
    .base  (reqBase),
    .count (reqCount),
    .addr  (mem_addr),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_done   <= 1'b0;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
      capValid  <= 1'b0;
      capIdx    <= '0;
      // NOTE: the image buffer is architecturally visible and must read as
      // zero after reset, so unlike a plain RAM it is reset word by word.
      for (int i = 0; i < N * N; i++) image_out[i] <= '0;
    end else begin
      // Read data returns one cycle after the strobe; capture it by the
      // index that was issued alongside that strobe.
      capValid <= mem_rd_en;
      capIdx   <= idx;
      if (capValid) image_out[capIdx] <= mem_rdata;

      case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (load_en) begin
              for (int i = 0; i < N * N; i++)
                if (CW'(i) >= reqCount) image_out[i] <= '0;
            end
            if (reqCount == '0) begin
              state   <= DONE;
              op_done <= 1'b1;
            end else if (load_en) begin
              state     <= LOAD;
              mem_rd_en <= 1'b1;
            end else begin
              state     <= SAVE;
              mem_wr_en <= 1'b1;
              mem_wdata <= save_img[0];
            end
          end
        end
        LOAD: begin
          if (last) begin
            state     <= LOAD_LAST;
            mem_rd_en <= 1'b0;
          end
        end
        LOAD_LAST: begin
          state   <= DONE;
          op_done <= 1'b1;
        end
        SAVE: begin
          if (last) begin
            state     <= DONE;
            mem_wr_en <= 1'b0;
            op_done   <= 1'b1;
          end else begin
            mem_wdata <= save_img[nextIdx];
          end
        end
        DONE: begin
          state   <= IDLE;
          op_done <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
